// File: rtl/mlp_pkg.sv
// mlp_pkg: shared score/index widths and types for the classifier output stage
package mlp_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH = $clog2(NUM_CLASSES);
  typedef logic signed [DATA_WIDTH-1:0] score_t;
  typedef logic [IDX_WIDTH-1:0] class_idx_t;
endpackage

// File: rtl/argmax_cmp_sel.sv
// argmax_cmp_sel: one step of the running argmax; strict compare so ties keep the lower index
module argmax_cmp_sel #(
  parameter int DATA_WIDTH = mlp_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH = mlp_pkg::IDX_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic signed [DATA_WIDTH-1:0] run_max,
  input  logic        [IDX_WIDTH-1:0]  run_idx,
  input  logic        [IDX_WIDTH-1:0]  cnt,
  input  logic                         first,
  output logic signed [DATA_WIDTH-1:0] nxt_max,
  output logic        [IDX_WIDTH-1:0]  nxt_idx
);
  logic gt;
  always_comb begin
    gt = in > run_max;
    nxt_max = (first || gt) ? in : run_max;
    nxt_idx = first ? '0 : (gt ? cnt : run_idx);
  end
endmodule

// File: rtl/layer_argmax_pipe.sv
// layer_argmax_pipe: per-frame argmax over the final layer's score stream,
// accepts one score every cycle with no backpressure
module layer_argmax_pipe #(
  parameter int DATA_WIDTH = mlp_pkg::DATA_WIDTH,
  parameter int NUM_CLASSES = mlp_pkg::NUM_CLASSES,
  parameter int IDX_WIDTH = $clog2(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic                         frame_clr,
  output logic        [IDX_WIDTH-1:0]  class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic                         valid_out,
  output logic                         busy
);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
  logic        [IDX_WIDTH-1:0]  cnt, cnt_nxt, run_idx, nxt_idx;
  logic signed [DATA_WIDTH-1:0] run_max, nxt_max;
  logic                         first, done;
  argmax_cmp_sel #(.DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_sel (
    .in(in), .run_max(run_max), .run_idx(run_idx), .cnt(cnt), .first(first),
    .nxt_max(nxt_max), .nxt_idx(nxt_idx)
  );
  // A clear restarts the frame, so a coincident sample is element 0 and can never complete one
  always_comb begin
    first = frame_clr || cnt == '0;
    done = valid_in && !frame_clr && cnt == LAST;
    cnt_nxt = done ? '0
            : valid_in ? (frame_clr ? IDX_WIDTH'(1) : cnt + IDX_WIDTH'(1))
            : frame_clr ? '0 : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run_max <= '0;
      run_idx <= '0;
      class_idx <= '0;
      max_val <= '0;
      valid_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      busy <= cnt_nxt != '0;
      valid_out <= done;
      if (valid_in) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
      end
      if (done) begin
        class_idx <= nxt_idx;
        max_val <= nxt_max;
      end
    end
  end
endmodule

// File: tb/tb_layer_argmax_pipe.sv
// tb_layer_argmax_pipe: table-driven frames plus clear/reset sequences, scoreboarded on valid_out
module tb_layer_argmax_pipe;
  import mlp_pkg::*;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, frame_clr = 1'b0, busy, valid_out;
  score_t in = '0, max_val;
  class_idx_t class_idx;
  int cyc = 0, n_cmp = 0, n_bad = 0;

  typedef struct { score_t s[10]; int idx; score_t val; int gap; } vec_t;
  typedef struct { int idx; score_t val; int c; } exp_t;
  exp_t q[$];
  vec_t v[8];

  layer_argmax_pipe dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in(in), .frame_clr(frame_clr),
    .class_idx(class_idx), .max_val(max_val), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) if (!rst && valid_out) begin
    if (q.size() == 0) chk("unexpected_valid_out", 1, 0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("class_idx", class_idx, e.idx);
      chk("max_val", max_val, e.val);
      chk("latency", cyc, e.c + 1);
    end
  end

  task automatic send(input score_t d, input logic clr, input logic vld);
    valid_in = vld; in = d; frame_clr = clr;
    @(posedge clk) #1;
    valid_in = 1'b0; frame_clr = 1'b0;
  endtask

  task automatic push(input int idx, input score_t val);
    exp_t e;
    e.idx = idx; e.val = val; e.c = cyc;
    q.push_back(e);
  endtask

  task automatic run_frame(input vec_t f);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) push(f.idx, f.val);
      send(f.s[i], 1'b0, 1'b1);
      repeat (f.gap) @(posedge clk) #1;
    end
  endtask

  initial begin
    v[0].s = '{0,3,7,2,9,1,0,4,5,6};           v[0].idx = 4; v[0].val = 9;   v[0].gap = 0;
    v[1].s = '{5,8,2,8,0,0,0,0,0,0};           v[1].idx = 1; v[1].val = 8;   v[1].gap = 0;
    v[2].s = '{100,0,0,0,0,0,0,0,0,0};         v[2].idx = 0; v[2].val = 100; v[2].gap = 0;
    v[3].s = '{0,0,0,0,0,0,0,0,0,100};         v[3].idx = 9; v[3].val = 100; v[3].gap = 0;
    v[4].s = '{1,2,3,4,5,6,7,8,9,10};          v[4].idx = 9; v[4].val = 10;  v[4].gap = 3;
    v[5].s = '{-5,-3,-9,-1,-2,-8,-7,-6,-4,-10}; v[5].idx = 3; v[5].val = -1;  v[5].gap = 0;
    v[6].s = '{-32768,32767,0,32767,1,2,3,4,5,6}; v[6].idx = 1; v[6].val = 32767; v[6].gap = 0;
    v[7].s = '{4,4,4,4,4,4,4,4,4,4};           v[7].idx = 0; v[7].val = 4;   v[7].gap = 1;
    #1;
    chk("rst_class_idx", class_idx, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk) #1 rst = 1'b0;
    @(posedge clk) #1;
    for (int i = 0; i < 8; i++) run_frame(v[i]);
    repeat (3) @(posedge clk) #1;
    chk("busy_idle", busy, 0);
    // partial frame aborted by a lone clear, then a fresh frame
    for (int i = 0; i < 4; i++) send(score_t'(50 + i), 1'b0, 1'b1);
    chk("busy_partial", busy, 1);
    send('0, 1'b1, 1'b0);
    chk("busy_after_clr", busy, 0);
    run_frame(v[0]);
    repeat (2) @(posedge clk) #1;
    // clear together with a sample: that sample is element 0
    for (int i = 0; i < 3; i++) send(score_t'(90), 1'b0, 1'b1);
    send(score_t'(50), 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      if (i == 9) push(0, 50);
      send(score_t'(i), 1'b0, 1'b1);
    end
    repeat (2) @(posedge clk) #1;
    // clear on what would be the last element: no result, sample restarts a frame
    for (int i = 0; i < 9; i++) send(score_t'(99), 1'b0, 1'b1);
    send(score_t'(7), 1'b1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      if (i == 9) push(0, 7);
      send(score_t'(i % 7), 1'b0, 1'b1);
    end
    repeat (2) @(posedge clk) #1;
    // asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) send(score_t'(200 + i), 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_class_idx", class_idx, 0);
    chk("arst_max_val", max_val, 0);
    chk("arst_valid_out", valid_out, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk) #1 rst = 1'b0;
    @(posedge clk) #1;
    run_frame(v[1]);
    repeat (4) @(posedge clk) #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/layer_argmax_pipe.md
Name: layer_argmax_pipe

Overview:
- Consumes the ReLU-activated output stream of the final neuron layer: one signed score per valid_in pulse, NUM_CLASSES scores per frame.
- Tracks the running maximum over each frame.
- After the last score of a frame, emits the winning class index and its score with a one-cycle valid pulse.
- Sits directly downstream of the neuron+ReLU stage. That stage has no backpressure, so this block must accept a score every cycle, indefinitely.

Parameters:
- DATA_WIDTH, 16, width of each signed score.
- NUM_CLASSES, 10, scores per frame; legal range 2 or more.
- IDX_WIDTH, $clog2(NUM_CLASSES), width of the class index and element counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- valid_in  input  1  score on in is valid this cycle.
- in  input  DATA_WIDTH signed  score from the ReLU stage.
- frame_clr  input  1  synchronous abort of a partial frame.
- class_idx  output  IDX_WIDTH  index of the maximum score in the completed frame.
- max_val  output  DATA_WIDTH signed  value of that maximum.
- valid_out  output  1  one-cycle pulse; class_idx/max_val valid.
- busy  output  1  high while a frame is partially received (cnt != 0).

Behaviour:
- Reset (async assert, rst=1): cnt=0, run_max=0, run_idx=0, class_idx=0, max_val=0, valid_out=0, busy=0. Reset mid-frame discards the partial frame; no valid_out is produced for it.
- Element counter cnt runs 0..NUM_CLASSES-1 and advances only on valid_in. Cycles without valid_in hold all state; gaps inside a frame are legal.
- On valid_in with cnt==0: run_max=in, run_idx=0, unconditionally.
- On valid_in with cnt>0: if in > run_max (signed, strict), then run_max=in and run_idx=cnt; otherwise hold.
- Ties go to the lowest index, because the comparison is strict.
- On valid_in with cnt==NUM_CLASSES-1, the frame is complete:
  - The final compare includes the current in.
  - Next cycle: class_idx and max_val are registered with the final result, valid_out=1, cnt=0.
  - Latency is 1 cycle from the last valid_in to valid_out.
- class_idx and max_val hold their values until the next frame completes.
- valid_out is high for exactly one cycle per completed frame.
- Back-to-back frames: the element-0 sample of a new frame may arrive in the cycle immediately after the last sample of the previous frame, i.e. in the same cycle valid_out is high. It is accepted normally, with no bubble required.
- frame_clr=1 alone: cnt=0, no valid_out; run_max and run_idx are don't-care.
- frame_clr=1 with valid_in=1 in the same cycle: the sample is taken as element 0 of a new frame (cnt becomes 1).
- frame_clr coinciding with the last element of a frame: clear wins. No valid_out, and the sample becomes element 0.
- busy = (cnt != 0), registered.
- Widths:
  - All compares are signed DATA_WIDTH; no arithmetic widening.
  - cnt compares against NUM_CLASSES-1 at IDX_WIDTH.
  - No wrap past NUM_CLASSES-1.

Decomposition:
- Shared package mlp_pkg:
  - constants DATA_WIDTH and NUM_CLASSES, and derived IDX_WIDTH;
  - typedef score_t (logic signed [DATA_WIDTH-1:0]);
  - typedef class_idx_t.
- One natural sub-module: argmax_cmp_sel, a combinational block.
  - Inputs: in, run_max, run_idx, cnt, first flag.
  - Outputs: next max and next idx.
  - Used so the compare/select can be unit-tested standalone.
- Counter, frame-complete detection and output registers stay in layer_argmax_pipe.

Test Plan:
- NUM_CLASSES=10, scores 0,3,7,2,9,1,0,4,5,6, one per cycle -> one cycle after the last score: valid_out=1, class_idx=4, max_val=9; valid_out low the next cycle.
- Tie: scores 5,8,2,8,0,0,0,0,0,0 -> class_idx=1, max_val=8 (lowest index wins).
- Maximum in the first or last slot: frame 100,0,..,0 -> idx 0; frame 0,..,0,100 -> idx 9, max_val=100, latency still 1 cycle.
- Back-to-back frames with no gap, then frame A with valid_in gaps of 3 idle cycles between samples -> two valid_out pulses, each with the correct idx/val; no sample lost.
- frame_clr after 4 samples, then a full 10-sample frame -> exactly one valid_out, for the new frame only. Separately, frame_clr and valid_in in the same cycle -> that sample counts as element 0.
- rst asserted asynchronously after 6 samples -> all outputs 0 immediately, busy=0. A subsequent full frame produces a correct result.
